// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous flush
// and an optional second (skid) entry that keeps in_ready_o off the combinational path.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    // Encoding equals the number of held entries, so count_o is the state register itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              in_fire, out_fire;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign count_o     = state_q;
    assign in_ready_o  = SKID_EN ? in_ready_q : (~out_valid_o | out_ready_i);

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data_i;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data_i;
                end else if (in_fire && SKID_EN) begin
                    state_d = ST_FULL;
                    skid_d  = in_data_i;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Squash wins over any transfer; payload registers keep whatever they captured.
        if (flush_i) begin
            state_d = ST_EMPTY;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: payload registers are reset too, because out_data_o must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (32-bit) and a single-entry instance (8-bit),
// both checked against queue-based models plus directed vectors and sequences.
module tb_pipe_stage_reg;

    logic clk_i = 1'b0;
    logic rst_n_i;
    always #5 clk_i = ~clk_i;

    // Skid instance (A)
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    // Single-entry instance (B)
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_count;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1)) dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .count_o(a_count)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b0)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .count_o(b_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference models: each stage is a FIFO of capacity 2 (A) or 1 (B).
    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    always @(posedge clk_i or negedge rst_n_i) begin : model_a
        bit inf, outf;
        if (!rst_n_i) begin
            qa.delete();
        end else begin
            inf  = a_in_valid && (qa.size() < 2);
            outf = a_out_ready && (qa.size() > 0);
            if (a_flush) qa.delete();
            else begin
                if (outf) void'(qa.pop_front());
                if (inf)  qa.push_back(a_in_data);
            end
        end
    end

    always @(posedge clk_i or negedge rst_n_i) begin : model_b
        bit inf, outf;
        if (!rst_n_i) begin
            qb.delete();
        end else begin
            inf  = b_in_valid && ((qb.size() == 0) || b_out_ready);
            outf = b_out_ready && (qb.size() > 0);
            if (b_flush) qb.delete();
            else begin
                if (outf) void'(qb.pop_front());
                if (inf)  qb.push_back(b_in_data);
            end
        end
    end

    task automatic check_a();
        check("a_valid", {31'd0, a_out_valid}, {31'd0, qa.size() > 0});
        if (qa.size() > 0) check("a_data", a_out_data, qa[0]);
        check("a_count", {30'd0, a_count}, qa.size());
        check("a_in_ready", {31'd0, a_in_ready}, {31'd0, qa.size() < 2});
    endtask

    task automatic check_b();
        check("b_valid", {31'd0, b_out_valid}, {31'd0, qb.size() > 0});
        if (qb.size() > 0) check("b_data", {24'd0, b_out_data}, {24'd0, qb[0]});
        check("b_count", {30'd0, b_count}, qb.size());
        check("b_in_ready", {31'd0, b_in_ready}, {31'd0, (qb.size() == 0) || b_out_ready});
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ord;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  ec;
        logic        er;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Row inputs apply for one edge; expectations are observed after that edge.
        tbl[0]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
        tbl[2]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 2'd1, 1'b1};
        tbl[4]  = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 32'hC, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1};
        tbl[6]  = '{1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 32'h1, 2'd1, 1'b1};
        tbl[7]  = '{1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 32'h1, 2'd2, 1'b0};
        tbl[8]  = '{1'b1, 32'hD, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
        tbl[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 32'hE, 1'b1, 1'b0, 1'b1, 32'hE, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 32'hF, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1};
        tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1};

        // Reset held with valid input offered.
        rst_n_i = 1'b0;
        a_flush = 0; a_in_valid = 1; a_in_data = 32'h1234; a_out_ready = 0;
        b_flush = 0; b_in_valid = 1; b_in_data = 8'h12;    b_out_ready = 0;
        repeat (3) @(negedge clk_i);
        check("rst_a_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_a_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_a_count", {30'd0, a_count}, 32'd0);
        check("rst_a_data", a_out_data, 32'd0);
        check("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        check("rst_b_data", {24'd0, b_out_data}, 32'd0);
        check("rst_b_count", {30'd0, b_count}, 32'd0);
        a_in_valid = 0; b_in_valid = 0;
        rst_n_i = 1'b1;

        // Directed vectors on the skid instance.
        for (int i = 0; i < 13; i++) begin
            a_in_valid = tbl[i].iv; a_in_data = tbl[i].d;
            a_out_ready = tbl[i].ord; a_flush = tbl[i].fl;
            @(negedge clk_i);
            check($sformatf("vec%0d_valid", i), {31'd0, a_out_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) check($sformatf("vec%0d_data", i), a_out_data, tbl[i].ed);
            check($sformatf("vec%0d_count", i), {30'd0, a_count}, {30'd0, tbl[i].ec});
            check($sformatf("vec%0d_ready", i), {31'd0, a_in_ready}, {31'd0, tbl[i].er});
            check_a();
        end
        a_flush = 0;

        // Streaming at full rate: one word per cycle, one cycle latency.
        a_out_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            a_in_valid = 1; a_in_data = k;
            @(negedge clk_i);
            check("stream_data", a_out_data, k);
            check("stream_count", {30'd0, a_count}, 32'd1);
            check_a();
        end
        a_in_valid = 0;
        @(negedge clk_i);
        check("stream_drain", {31'd0, a_out_valid}, 32'd0);

        // Single-entry instance: combinational ready follows out_ready.
        b_in_valid = 1; b_in_data = 8'h55; b_out_ready = 0;
        @(negedge clk_i);
        check("b_hold_data", {24'd0, b_out_data}, 32'h55);
        check("b_hold_ready", {31'd0, b_in_ready}, 32'd0);
        check_b();
        b_in_data = 8'h66; b_out_ready = 1;
        #1;
        check("b_same_cycle_ready", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk_i);
        check("b_next_data", {24'd0, b_out_data}, 32'h66);
        check("b_next_valid", {31'd0, b_out_valid}, 32'd1);
        check_b();
        b_in_valid = 0;
        @(negedge clk_i);
        check_b();

        // Reset asserted while full: outputs drop without a clock edge.
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h21;
        @(negedge clk_i);
        a_in_data = 32'h22;
        @(negedge clk_i);
        check("full_count", {30'd0, a_count}, 32'd2);
        a_in_valid = 0;
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, a_out_valid}, 32'd0);
        check("async_rst_count", {30'd0, a_count}, 32'd0);
        check("async_rst_ready", {31'd0, a_in_ready}, 32'd1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        a_in_valid = 1; a_in_data = 32'h77; a_out_ready = 1;
        @(negedge clk_i);
        check("post_rst_data", a_out_data, 32'h77);
        check("post_rst_count", {30'd0, a_count}, 32'd1);
        a_in_valid = 0;
        @(negedge clk_i);
        check("post_rst_alone", {31'd0, a_out_valid}, 32'd0);

        // Randomized traffic on both instances against the models.
        for (int n = 0; n < 400; n++) begin
            a_in_valid  = ($urandom_range(9) < 7);
            a_in_data   = $urandom;
            a_out_ready = ($urandom_range(9) < 6);
            a_flush     = ($urandom_range(29) == 0);
            b_in_valid  = ($urandom_range(9) < 7);
            b_in_data   = 8'($urandom);
            b_out_ready = ($urandom_range(9) < 6);
            b_flush     = ($urandom_range(29) == 0);
            @(negedge clk_i);
            check_a();
            check_b();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
